// File: rtl/gcd_pkg.sv
// Shared constants for the GCD controller: FSM state encoding and
// datapath mux select values.
package gcd_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_A = 3'd1;
   localparam logic [2:0] S_LOAD_B = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   // X/Y operand mux selects
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // bus mux select
   localparam logic SEL_EXT = 1'b0;
   localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/gcd_iter_counter.sv
// Iteration counter: synchronous clear/increment, tc when count==MAX_ITER.
// Ports: clk, rst_n, clr, inc in; count, tc out.
module gcd_iter_counter #(
   parameter int          ITER_W   = 16,
   parameter int unsigned MAX_ITER = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [ITER_W-1:0] count,
   output logic              tc
);

   logic [ITER_W-1:0] count_q;
   logic [ITER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = (count_q == ITER_W'(MAX_ITER));

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the GCD subtract-compare datapath.
// Ports: start/op_a/op_b request in, eq/lt/gt flags in; ldA/ldB, sel1/sel2/
// sel_in, dp_data drive the datapath; busy/done/err_*/iter_count report status.
module gcd_controller
   import gcd_pkg::*;
#(
   parameter int          WIDTH    = 16,
   parameter int          ITER_W   = 16,
   parameter int unsigned MAX_ITER = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   input  logic              eq,
   input  logic              lt,
   input  logic              gt,
   output logic              ldA,
   output logic              ldB,
   output logic              sel1,
   output logic              sel2,
   output logic              sel_in,
   output logic [WIDTH-1:0]  dp_data,
   output logic              busy,
   output logic              done,
   output logic              err_zero,
   output logic              err_timeout,
   output logic [ITER_W-1:0] iter_count
);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             ez_q, ez_d;
   logic             et_q, et_d;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_tc;

   gcd_iter_counter #(
      .ITER_W   (ITER_W),
      .MAX_ITER (MAX_ITER)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (iter_count),
      .tc    (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ez_d    = ez_q;
      et_d    = et_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      ldA     = 1'b0;
      ldB     = 1'b0;
      sel1    = SEL_A;
      sel2    = SEL_A;
      sel_in  = SEL_EXT;
      dp_data = '0;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = op_a;
               b_d     = op_b;
               ez_d    = 1'b0;
               et_d    = 1'b0;
               cnt_clr = 1'b1;
               if (op_a == '0 || op_b == '0) begin
                  ez_d    = 1'b1;
                  state_d = S_ERR;
               end else begin
                  state_d = S_LOAD_A;
               end
            end
         end
         S_LOAD_A: begin
            dp_data = a_q;
            ldA     = 1'b1;
            state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            dp_data = b_q;
            ldB     = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            // the MAX_ITER-th subtraction has already been applied
            if (cnt_tc) begin
               et_d    = 1'b1;
               state_d = S_ERR;
            end else if (eq) begin
               state_d = S_DONE;
            end else if (gt) begin
               sel1    = SEL_A;
               sel2    = SEL_B;
               sel_in  = SEL_SUB;
               ldA     = 1'b1;
               cnt_inc = 1'b1;
            end else if (lt) begin
               sel1    = SEL_B;
               sel2    = SEL_A;
               sel_in  = SEL_SUB;
               ldB     = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         S_DONE, S_ERR: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ez_q    <= 1'b0;
         et_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ez_q    <= ez_d;
         et_q    <= et_d;
      end
   end

   assign busy        = (state_q == S_LOAD_A) ||
                        (state_q == S_LOAD_B) ||
                        (state_q == S_RUN);
   assign err_zero    = ez_q;
   assign err_timeout = et_q;

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM that drives the GCD subtract-compare datapath.
- Accepts two operands with a start/done handshake, then sequences two operand loads onto the datapath input bus.
- Iterates one subtraction per cycle, steering the datapath from its eq/lt/gt flags until the operands are equal.
- Guards against zero operands, which would otherwise never terminate, and against runaway iteration with a bounded counter.

Parameters:
- WIDTH, 16, operand and datapath bus width.
- ITER_W, 16, width of the iteration counter.
- MAX_ITER, 16'hFFFF, subtraction limit before timeout. Must be ≥1 and ≤ 2^ITER_W−1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  operand A; captured on the accepted start
- op_b  input  WIDTH  operand B; captured on the accepted start
- eq  input  1  datapath A==B
- lt  input  1  datapath A<B
- gt  input  1  datapath A>B
- ldA  output  1  datapath register A load
- ldB  output  1  datapath register B load
- sel1  output  1  X mux select (0=A, 1=B)
- sel2  output  1  Y mux select (0=A, 1=B)
- sel_in  output  1  bus mux select (0=data_in, 1=subtractor)
- dp_data  output  WIDTH  drives datapath data_in
- busy  output  1  high in LOAD_A, LOAD_B, RUN
- done  output  1  one-cycle completion pulse
- err_zero  output  1  last request had a zero operand
- err_timeout  output  1  last request hit MAX_ITER
- iter_count  output  ITER_W  subtractions performed for the last/current request

Behaviour:
- Reset values: state=IDLE, all outputs 0, internal operand latches 0, iter_count 0.
- Reset is async assert, sync deassert by the system. Reset mid-operation aborts to IDLE with no done pulse.
- IDLE:
  - start=1 latches op_a/op_b, clears err_zero, err_timeout and iter_count.
  - If either operand is 0: go to ERR and set err_zero. No datapath loads occur.
  - Otherwise go to LOAD_A.
  - start is ignored in every other state.
- LOAD_A: sel_in=0, dp_data=latched A, ldA=1. Next state LOAD_B.
- LOAD_B: sel_in=0, dp_data=latched B, ldB=1. Next state RUN.
- RUN (flags reflect the registers loaded on the previous edge):
  - eq: go to DONE, no load.
  - gt: A←A−B, driven as sel1=0, sel2=1, sel_in=1, ldA=1; iter_count+1.
  - lt: B←B−A, driven as sel1=1, sel2=0, sel_in=1, ldB=1; iter_count+1.
  - If a subtraction would make iter_count reach MAX_ITER, that subtraction still executes, then go to ERR with err_timeout=1.
  - Flags are one-hot by contract. If none or several are set, priority is eq > gt > lt.
- DONE: done=1 for one cycle, then IDLE. The GCD is held in datapath A (and B).
- ERR: done=1 for one cycle, then IDLE. The error flags stay set until the next accepted start.
- When no load is active, dp_data=0 and sel1/sel2/sel_in=0.
- Latency: for N subtractions, done is high in cycle t0+N+4, where t0 is the start-sampling edge. A zero-operand error gives done at t0+1.
- A start asserted in the same cycle as done is not accepted (FSM is in DONE/ERR). The earliest accepted restart is the IDLE cycle that follows.

Decomposition:
- gcd_pkg holds:
  - state encoding: IDLE, LOAD_A, LOAD_B, RUN, DONE, ERR;
  - mux select constants: SEL_A=0, SEL_B=1, SEL_EXT=0, SEL_SUB=1.
- One sub-module, gcd_iter_counter: clear/increment with a terminal-count flag at MAX_ITER.

Test Plan:
- op_a=12, op_b=8, with the datapath attached → loads A then B; RUN does gt then lt then eq. done at t0+6, iter_count=2, A=B=4, no errors.
- op_a=7, op_b=7 → no subtraction; done at t0+4, iter_count=0, A=7.
- op_a=0, op_b=5 → done at t0+1, err_zero=1; ldA/ldB never asserted.
- MAX_ITER=4, op_a=100, op_b=1 → exactly 4 ldA pulses; done at t0+8; err_timeout=1, iter_count=4, A=96.
- start pulsed repeatedly while busy with 48/18 → ignored; result A=6, iter_count=4. A second start in the done cycle is not accepted; a start in the next cycle runs normally.
- rst_n dropped in RUN for 1270/55 → all outputs 0 immediately, no done. A fresh start 21/14 then gives A=7 with iter_count=2.
